// File: rtl/ahfp_pkg.sv
// Shared definitions for the ahfp floating-point datapath: format defaults,
// flag positions, op encodings, special-case codes and constant builders.
package ahfp_pkg;

    localparam int AHFP_EXP_W = 8;
    localparam int AHFP_MAN_W = 23;

    // Bit positions inside the 4-bit flag vector {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic AHFP_OP_ADD = 1'b0;
    localparam logic AHFP_OP_SUB = 1'b1;

    // Special-case outcome decided at unpack time and carried to the packer
    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_NAN  = 2'd1,
        SPC_INF  = 2'd2
    } ahfp_spc_e;

    function automatic int ahfp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits
    function automatic logic [63:0] ahfp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[6'(man_w + i)] = 1'b1;
        v[6'(man_w - 1)] = 1'b1;
        return v;
    endfunction

    // Signed infinity, right-aligned in 64 bits
    function automatic logic [63:0] ahfp_inf(input logic sgn, input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[6'(man_w + i)] = 1'b1;
        v[6'(exp_w + man_w)] = sgn;
        return v;
    endfunction

endpackage

// File: rtl/ahfp_lzc.sv
// Leading-zero counter; an all-zero input returns W.
module ahfp_lzc #(
    parameter int W = 27,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/ahfp_add_sub_pipe.sv
// Four-stage IEEE-754 adder/subtractor with runtime op select, valid/ready
// handshake under a single global stall, and a tag carried with each op.
// Stages: S1 unpack/swap/align, S2 magnitude add/sub, S3 normalise, S4 round/pack.
module ahfp_add_sub_pipe
    import ahfp_pkg::*;
#(
    parameter int EXP_W   = AHFP_EXP_W,
    parameter int MAN_W   = AHFP_MAN_W,
    parameter int TAG_W   = 4,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             out_flags
);

    localparam int FW   = 1 + EXP_W + MAN_W;   // packed float width
    localparam int MW   = MAN_W + 4;           // hidden + fraction + guard/round/sticky
    localparam int EW   = EXP_W + 2;           // signed working exponent
    localparam int LZ_W = $clog2(MW + 1);

    localparam logic [63:0]   QNAN64 = ahfp_qnan(EXP_W, MAN_W);
    localparam logic [63:0]   INF64  = ahfp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);

    if (LATENCY != 4) begin : g_latency_check
        $error("ahfp_add_sub_pipe: LATENCY must be 4");
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        ahfp_spc_e        spc;
        logic             spc_s;     // sign of a special Inf result
        logic             sgn;       // sign of the larger operand
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [MW-1:0]    mb;        // larger magnitude
        logic [MW-1:0]    ms;        // smaller magnitude, aligned, sticky in bit 0
    } s1_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        ahfp_spc_e        spc;
        logic             spc_s;
        logic             sgn;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [MW:0]      sum;       // one extra bit for the carry-out
    } s2_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        ahfp_spc_e        spc;
        logic             spc_s;
        logic             sgn;
        logic             zero;      // exact zero magnitude
        logic [EW-1:0]    exp;       // two's complement
        logic [MW-1:0]    man;       // hidden bit at MW-1
    } s3_t;

    logic [LATENCY:1] vld_pipe_q, vld_pipe_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    s3_t              s3_q, s3_d;
    logic [FW-1:0]    result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [3:0]       flags_q, flags_d;
    logic             adv;

    // S1 working signals
    logic                   a_s, b_es, a_nz, b_nz, a_nan, b_nan, a_inf, b_inf, swap;
    logic [EXP_W-1:0]       a_e, b_e, e_small, d;
    logic [MAN_W-1:0]       a_f, b_f;
    logic [MW-1:0]          a_m, b_m, m_small;
    logic [EXP_W+MAN_W-1:0] a_key, b_key;
    logic [2*MW-1:0]        wide;

    // S3/S4 working signals
    logic [LZ_W-1:0]        lz;
    logic [MAN_W:0]         kept;
    logic [MAN_W+1:0]       rounded;
    logic                   rnd_up, inexact;
    logic [EW-1:0]          e_r;

    assign out_valid = vld_pipe_q[LATENCY];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign result    = result_q;
    assign out_tag   = tag_q;
    assign out_flags = flags_q;

    // Valid bits advance as one shift register under the global enable
    always_comb begin
        vld_pipe_d = {vld_pipe_q[LATENCY-1:1], in_valid};
    end

    // S1: classify, flush subnormals, order by magnitude and align the smaller operand
    always_comb begin
        a_s   = dataa[FW-1];
        a_e   = dataa[FW-2:MAN_W];
        a_f   = dataa[MAN_W-1:0];
        b_es  = datab[FW-1] ^ (in_op == AHFP_OP_SUB);
        b_e   = datab[FW-2:MAN_W];
        b_f   = datab[MAN_W-1:0];
        a_nz  = |a_e;
        b_nz  = |b_e;
        a_nan = (&a_e) && (|a_f);
        b_nan = (&b_e) && (|b_f);
        a_inf = (&a_e) && !(|a_f);
        b_inf = (&b_e) && !(|b_f);
        a_m   = a_nz ? {1'b1, a_f, 3'b000} : '0;
        b_m   = b_nz ? {1'b1, b_f, 3'b000} : '0;
        a_key = a_nz ? {a_e, a_f} : '0;
        b_key = b_nz ? {b_e, b_f} : '0;
        swap  = b_key > a_key;

        s1_d         = '0;
        s1_d.tag     = in_tag;
        s1_d.eff_sub = a_s ^ b_es;
        s1_d.sgn     = swap ? b_es : a_s;
        s1_d.exp     = swap ? b_e : a_e;
        s1_d.mb      = swap ? b_m : a_m;
        m_small      = swap ? a_m : b_m;
        e_small      = swap ? a_e : b_e;
        d            = s1_d.exp - e_small;

        // Beyond MW-2 positions the whole smaller operand collapses into sticky
        wide = '0;
        if (int'(d) >= MW - 1) begin
            s1_d.ms = {{(MW-1){1'b0}}, |m_small};
        end else begin
            wide    = {m_small, {MW{1'b0}}} >> d;
            s1_d.ms = wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |wide[MW-1:0]};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_es))) begin
            s1_d.spc = SPC_NAN;
        end else if (a_inf || b_inf) begin
            s1_d.spc   = SPC_INF;
            s1_d.spc_s = a_inf ? a_s : b_es;
        end
    end

    // S2: magnitude add or subtract; ordering guarantees a non-negative difference
    always_comb begin
        s2_d         = '0;
        s2_d.tag     = s1_q.tag;
        s2_d.spc     = s1_q.spc;
        s2_d.spc_s   = s1_q.spc_s;
        s2_d.sgn     = s1_q.sgn;
        s2_d.eff_sub = s1_q.eff_sub;
        s2_d.exp     = s1_q.exp;
        s2_d.sum     = s1_q.eff_sub ? ({1'b0, s1_q.mb} - {1'b0, s1_q.ms})
                                    : ({1'b0, s1_q.mb} + {1'b0, s1_q.ms});
    end

    ahfp_lzc #(.W(MW)) u_lzc (
        .din (s2_q.sum[MW-1:0]),
        .cnt (lz)
    );

    // S3: normalise so the hidden bit sits at MW-1, folding lost bits into sticky
    always_comb begin
        s3_d       = '0;
        s3_d.tag   = s2_q.tag;
        s3_d.spc   = s2_q.spc;
        s3_d.spc_s = s2_q.spc_s;
        s3_d.zero  = ~|s2_q.sum;
        // Cancellation gives +0; only like-signed zeros keep a negative sign
        s3_d.sgn   = s3_d.zero ? (s2_q.sgn & ~s2_q.eff_sub) : s2_q.sgn;
        if (s2_q.sum[MW]) begin
            s3_d.man = {s2_q.sum[MW:2], s2_q.sum[1] | s2_q.sum[0]};
            s3_d.exp = {2'b00, s2_q.exp} + EW'(1);
        end else begin
            s3_d.man = s2_q.sum[MW-1:0] << lz;
            s3_d.exp = {2'b00, s2_q.exp} - EW'(lz);
        end
    end

    // S4: round to nearest even, then pack with range checks and special overrides
    always_comb begin
        kept     = s3_q.man[MW-1:3];
        inexact  = |s3_q.man[2:0];
        rnd_up   = s3_q.man[2] && (s3_q.man[1] || s3_q.man[0] || kept[0]);
        rounded  = {1'b0, kept} + (MAN_W+2)'(rnd_up);
        // A rounding carry leaves the fraction all-zero, so only the exponent moves
        e_r      = s3_q.exp + EW'(rounded[MAN_W+1]);
        tag_d    = s3_q.tag;
        flags_d  = '0;
        result_d = {s3_q.sgn, e_r[EXP_W-1:0], rounded[MAN_W-1:0]};

        if (s3_q.spc == SPC_NAN) begin
            result_d               = QNAN64[FW-1:0];
            flags_d[FLAG_INVALID]  = 1'b1;
        end else if (s3_q.spc == SPC_INF) begin
            result_d = {s3_q.spc_s, INF64[FW-2:0]};
        end else if (s3_q.zero) begin
            result_d = {s3_q.sgn, {(FW-1){1'b0}}};
        end else if (!e_r[EW-1] && (e_r >= EMAX)) begin
            result_d                = {s3_q.sgn, INF64[FW-2:0]};
            flags_d[FLAG_OVERFLOW]  = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
            result_d                = {s3_q.sgn, {(FW-1){1'b0}}};
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = inexact;
        end else begin
            flags_d[FLAG_INEXACT]   = inexact;
        end
    end

    // All stages share one enable; reset drops every in-flight op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            result_q   <= '0;
            tag_q      <= '0;
            flags_q    <= '0;
        end else if (adv) begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
            flags_q    <= flags_d;
        end
    end

endmodule

// File: tb/tb_ahfp_add_sub_pipe.sv
// Bench for ahfp_add_sub_pipe (binary32): a value-level reference model feeds a
// scoreboard checked on every output transfer, plus literal pins of the model.
module tb_ahfp_add_sub_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_op = 1'b0;
    logic [3:0]  in_tag = '0;
    logic [31:0] dataa = '0, datab = '0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [3:0]  out_tag, out_flags;

    int n_cmp = 0, n_fail = 0, cyc = 0, n_out = 0;
    bit lat_mode = 1'b0, bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;   // out_ready sequence 1,0,0,1
    int bp_k = 0;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [31:0] a, b;
        logic        op;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;
    vec_t vt[16];

    ahfp_add_sub_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag), .dataa(dataa), .datab(datab),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact value arithmetic on 64-bit integers, then RNE to 24 bits
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                  output logic [31:0] r, output logic [3:0] f);
        logic sa, sb, sx, sy, inx;
        int ea, eb, ex, ey, d, p, sh, e;
        longint unsigned mx, my, A, B, N, kept, rem, half;
        sa = a[31]; sb = b[31] ^ op;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        r = '0; f = '0;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255 && sa != sb)) begin
            r = 32'h7FC00000; f = 4'b1000; return;
        end
        if (ea == 255) begin r = {sa, 8'hFF, 23'h0}; return; end
        if (eb == 255) begin r = {sb, 8'hFF, 23'h0}; return; end
        if (ea == 0 && eb == 0) begin r = {sa & sb, 31'h0}; return; end
        if (ea == 0) begin r = {sb, b[30:0]}; return; end
        if (eb == 0) begin r = a; return; end
        if (b[30:0] > a[30:0]) begin
            sx = sb; ex = eb; mx = {40'h0, 1'b1, b[22:0]};
            sy = sa; ey = ea; my = {40'h0, 1'b1, a[22:0]};
        end else begin
            sx = sa; ex = ea; mx = {40'h0, 1'b1, a[22:0]};
            sy = sb; ey = eb; my = {40'h0, 1'b1, b[22:0]};
        end
        d = ex - ey;
        A = mx << 32;
        B = (d > 32) ? 64'd1 : ((my << 32) >> d);
        N = (sx == sy) ? A + B : A - B;
        if (N == 0) return;
        p = 0;
        for (int i = 0; i < 64; i++) if (N[i]) p = i;
        e    = ex + p - 55;
        sh   = p - 23;
        kept = N >> sh;
        rem  = N - (kept << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && kept[0])) kept++;
        if (kept == (64'd1 << 24)) begin kept >>= 1; e++; end
        if (e >= 255) begin
            r = {sx, 8'hFF, 23'h0}; f = 4'b0101;
        end else if (e <= 0) begin
            r = {sx, 31'h0}; f = {3'b001, inx};
        end else begin
            r = {sx, e[7:0], kept[22:0]}; f = {3'b000, inx};
        end
    endfunction

    // Scoreboard: transfers are judged at the falling edge before the rising edge that takes them
    initial forever begin
        exp_t e;
        logic [31:0] mr;
        logic [3:0]  mf;
        @(negedge clk);
        if (!reset_n) begin
            sbq.delete();
            continue;
        end
        chk("in_ready_vs_adv", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            n_out++;
            chk("output_has_pending_op", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("result", result, e.r);
                chk("flags", out_flags, e.f);
                chk("tag", out_tag, e.tag);
                if (e.lat) chk("latency", cyc - e.cyc, 4);
            end
        end
        if (in_valid && in_ready) begin
            model(dataa, datab, in_op, mr, mf);
            e.r = mr; e.f = mf; e.tag = in_tag; e.cyc = cyc; e.lat = lat_mode;
            sbq.push_back(e);
        end
    end

    // Backpressure pattern driver
    initial forever begin
        @(posedge clk); #1;
        if (bp_mode) begin
            out_ready = bp_pat[bp_k % 4];
            bp_k++;
        end
    end

    // Called at rising edge + 1; returns at rising edge + 1 after the op is taken
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [3:0] tag);
        bit acc;
        int t;
        t = 0;
        in_valid = 1'b1; dataa = a; datab = b; in_op = op; in_tag = tag;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (sbq.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_queue_empty", sbq.size(), 0);
    endtask

    initial begin
        logic [31:0] mr;
        logic [3:0]  mf;
        int n0;
        vt[0]  = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'h0};
        vt[1]  = '{32'hC0A00000, 32'hC0400000, 1'b0, 32'hC1000000, 4'h0};
        vt[2]  = '{32'hC0A00000, 32'hC0400000, 1'b1, 32'hC0000000, 4'h0};
        vt[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
        vt[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        vt[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
        vt[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        vt[7]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
        vt[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h2};
        vt[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        vt[10] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0};
        vt[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};
        vt[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0};
        vt[13] = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'h0};
        vt[14] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'h1};
        vt[15] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0};

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_out_flags", out_flags, 0);
        reset_n = 1'b1;
        #1;
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Pin the reference model against hand-computed results
        foreach (vt[i]) begin
            model(vt[i].a, vt[i].b, vt[i].op, mr, mf);
            chk($sformatf("model_pin_%0d", i), {mf, mr}, {vt[i].f, vt[i].r});
        end

        // Directed vectors back-to-back with no stall: fixed 4-cycle latency
        lat_mode = 1'b1;
        foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].op, 4'(i));
        drain();
        lat_mode = 1'b0;

        // Backpressure: tags 0..7 must emerge in order exactly once
        n0 = n_out;
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(vt[i].a, vt[i + 8].b, 1'(i & 1), 4'(i));
        drain();
        bp_mode = 1'b0;
        out_ready = 1'b1;
        chk("bp_output_count", n_out - n0, 8);

        // Reset with ops in flight and a stalled valid output
        out_ready = 1'b0;
        send(vt[0].a, vt[0].b, 1'b0, 4'd5);
        send(vt[1].a, vt[1].b, 1'b0, 4'd6);
        send(vt[2].a, vt[2].b, 1'b1, 4'd7);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("stalled_out_valid", out_valid, 1);
        chk("stalled_out_tag", out_tag, 5);
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_result", result, 0);
        chk("midreset_out_tag", out_tag, 0);
        chk("midreset_out_flags", out_flags, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        n0 = n_out;
        repeat (12) @(posedge clk); #1;
        chk("no_stale_outputs", n_out - n0, 0);

        // One more op after recovery
        lat_mode = 1'b1;
        send(vt[13].a, vt[13].b, vt[13].op, 4'd9);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
